regfile_wr_arbiter: RTL and testbench

//  Shares the register file's single write port (we3/a3/wd3) between NUM_REQ writeback

---
 rtl/regfile_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port (we3/a3/wd3) between NUM_REQ sources,
// with per-requester lock. Optional stats counters under `define RFARB_STATS_EN.
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_lock,
  input  logic [NUM_REQ*5-1:0]    req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    we3,
  output logic [4:0]              a3,
  output logic [XLEN-1:0]         wd3,
  output logic [IDW-1:0]          grant_id
`ifdef RFARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]   grant_cnt,
  output logic [15:0]             x0_drop_cnt
`endif
);

  // state       | meaning
  // ST_UNLOCKED | plain round-robin from ptr
  // ST_LOCKED   | owner_q keeps the grant while it stays valid
  typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_e;

  lock_state_e      state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             we3_q, we3_d;
  logic [4:0]       a3_q, a3_d;
  logic [XLEN-1:0]  wd3_q, wd3_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [4:0]       sel_addr;
  logic [XLEN-1:0]  sel_data;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    if (state_q == ST_LOCKED && req_valid[owner_q]) begin
      gnt_found = 1'b1;
      gnt_idx   = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_found && req_valid[rr_idx(ptr_q, k)]) begin
          gnt_found = 1'b1;
          gnt_idx   = rr_idx(ptr_q, k);
        end
      end
    end
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_addr = req_addr[5*gnt_idx +: 5];
  assign sel_data = req_data[XLEN*gnt_idx +: XLEN];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    we3_d      = 1'b0;
    a3_d       = a3_q;
    wd3_d      = wd3_q;
    grant_id_d = grant_id_q;
    if (gnt_found) begin
      // Every transfer re-evaluates the lock, so an RR winner can open a fresh lock
      state_d    = req_lock[gnt_idx] ? ST_LOCKED : ST_UNLOCKED;
      owner_d    = gnt_idx;
      ptr_d      = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      we3_d      = (sel_addr != 5'd0);
      a3_d       = sel_addr;
      wd3_d      = sel_data;
      grant_id_d = gnt_idx;
    end else begin
      state_d = ST_UNLOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      owner_q    <= '0;
      ptr_q      <= '0;
      we3_q      <= 1'b0;
      a3_q       <= '0;
      wd3_q      <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      we3_q      <= we3_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign we3      = we3_q;
  assign a3       = a3_q;
  assign wd3      = wd3_q;
  assign grant_id = grant_id_q;

`ifdef RFARB_STATS_EN
  logic [NUM_REQ*16-1:0] gcnt_q, gcnt_d;
  logic [15:0]           x0_q, x0_d;

  always_comb begin
    gcnt_d = gcnt_q;
    x0_d   = x0_q;
    if (gnt_found) begin
      if (gcnt_q[16*gnt_idx +: 16] != 16'hFFFF)
        gcnt_d[16*gnt_idx +: 16] = gcnt_q[16*gnt_idx +: 16] + 16'd1;
      if (sel_addr == 5'd0 && x0_q != 16'hFFFF)
        x0_d = x0_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt_q <= '0;
      x0_q   <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      x0_q   <= x0_d;
    end
  end

  assign grant_cnt   = gcnt_q;
  assign x0_drop_cnt = x0_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: vector table, directed corner sequences, random vs. model.
module tb_regfile_wr_arbiter;
  localparam int N = 3;
  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_lock, req_ready;
  logic [N*5-1:0]    req_addr;
  logic [N*XLEN-1:0] req_data;
  logic              we3;
  logic [4:0]        a3;
  logic [XLEN-1:0]   wd3;
  logic [1:0]        grant_id;
`ifdef RFARB_STATS_EN
  logic [N*16-1:0]   grant_cnt;
  logic [15:0]       x0_drop_cnt;
`endif

  logic [4:0]      addr [N];
  logic [XLEN-1:0] data [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[5*i +: 5]       = addr[i];
      req_data[XLEN*i +: XLEN] = data[i];
    end
  end

  regfile_wr_arbiter #(.NUM_REQ(N), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .we3(we3), .a3(a3), .wd3(wd3), .grant_id(grant_id)
`ifdef RFARB_STATS_EN
    , .grant_cnt(grant_cnt), .x0_drop_cnt(x0_drop_cnt)
`endif
  );

  // Regfile fed by the DUT write port; x0 is hard-wired zero.
  logic [XLEN-1:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (we3 && a3 != 5'd0) rf[a3] <= wd3;

  int total = 0;
  int bad = 0;

  // Reference model state in plain integers
  int       m_ptr, m_owner, m_gid;
  bit       m_locked;
  bit       m_we3;
  int       m_a3;
  logic [XLEN-1:0] m_wd3;
  int       m_gcnt [N];
  int       m_x0;
  logic [N-1:0] last_ready;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (m_locked && req_valid[m_owner]) return m_owner;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_gid = 0; m_locked = 0; m_we3 = 0; m_a3 = 0; m_wd3 = '0;
    m_x0 = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
  endtask

  // Inputs are set while clk is low; one full cycle with checks on both sides of the edge.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    last_ready = req_ready;
    check("ready", {61'd0, req_ready}, {61'd0, exp_rdy});
    @(posedge clk);
    if (reset) model_reset();
    else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      m_locked = req_lock[g];
      m_owner = g;
      m_we3 = (addr[g] != 0);
      m_a3 = int'(addr[g]);
      m_wd3 = data[g];
      m_gid = g;
      if (m_gcnt[g] < 16'hFFFF) m_gcnt[g]++;
      if (addr[g] == 0 && m_x0 < 16'hFFFF) m_x0++;
    end else begin
      m_we3 = 0;
      m_locked = 0;
    end
    #1;
    check("we3", {63'd0, we3}, {63'd0, m_we3});
    check("a3", {59'd0, a3}, 64'(m_a3));
    check("wd3", {32'd0, wd3}, {32'd0, m_wd3});
    check("grant_id", {62'd0, grant_id}, 64'(m_gid));
`ifdef RFARB_STATS_EN
    for (int i = 0; i < N; i++)
      check("grant_cnt", {48'd0, grant_cnt[16*i +: 16]}, 64'(m_gcnt[i]));
    check("x0_drop_cnt", {48'd0, x0_drop_cnt}, 64'(m_x0));
`endif
    @(negedge clk);
  endtask

  task automatic set_data(input int s);
    for (int i = 0; i < N; i++) data[i] = 32'hA000_0000 | (i << 24) | s;
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] lock;
    int           exp_gnt;
  } vec_t;
  vec_t vecs [13];

  initial begin
    // 0..5: plain RR with everyone valid; 6..12: lock burst by req2 then RR resumes at 0
    vecs[0]  = '{3'b111, 3'b000, 0};
    vecs[1]  = '{3'b111, 3'b000, 1};
    vecs[2]  = '{3'b111, 3'b000, 2};
    vecs[3]  = '{3'b111, 3'b000, 0};
    vecs[4]  = '{3'b111, 3'b000, 1};
    vecs[5]  = '{3'b111, 3'b000, 2};
    vecs[6]  = '{3'b010, 3'b000, 1};
    vecs[7]  = '{3'b111, 3'b100, 2};
    vecs[8]  = '{3'b111, 3'b100, 2};
    vecs[9]  = '{3'b111, 3'b100, 2};
    vecs[10] = '{3'b111, 3'b000, 2};
    vecs[11] = '{3'b111, 3'b000, 0};
    vecs[12] = '{3'b111, 3'b000, 1};

    model_reset();
    reset = 1'b1; req_valid = '0; req_lock = '0;
    for (int i = 0; i < N; i++) begin addr[i] = 5'd0; data[i] = '0; end
    @(posedge clk); @(negedge clk);

    // Reset held two cycles with all valid
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin addr[i] = 5'd3; data[i] = 32'h5555_0000 + i; end
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    check("first_grant_after_reset", {61'd0, last_ready}, 64'd1);

    reset = 1'b1; req_valid = '0; cycle(); reset = 1'b0;

    // Table: RR fairness then lock burst
    for (int i = 0; i < N; i++) addr[i] = 5'd5;
    for (int v = 0; v < 6; v++) begin
      req_valid = vecs[v].valid; req_lock = vecs[v].lock; set_data(v);
      cycle();
      check("vec_grant", {61'd0, last_ready}, 64'(1 << vecs[v].exp_gnt));
    end
    req_valid = '0; req_lock = '0; cycle();
    check("rf_x5_rr", {32'd0, rf[5]}, {32'd0, 32'hA200_0005});
    for (int v = 6; v < 13; v++) begin
      req_valid = vecs[v].valid; req_lock = vecs[v].lock; set_data(v);
      cycle();
      check("vec_grant", {61'd0, last_ready}, 64'(1 << vecs[v].exp_gnt));
    end

    // Latency: write lands in regfile one edge after the transfer
    req_valid = 3'b010; req_lock = '0; addr[1] = 5'd7; data[1] = 32'hDEADBEEF;
    cycle();
    check("lat_rf_before_commit", {32'd0, rf[7]}, {32'd0, 32'h0});
    req_valid = '0; cycle();
    check("lat_rf_x7", {32'd0, rf[7]}, {32'd0, 32'hDEADBEEF});

    // x0 filter
    reset = 1'b1; cycle(); reset = 1'b0;
    req_valid = 3'b001; addr[0] = 5'd0; data[0] = 32'h1234;
    cycle();
    check("x0_ready", {61'd0, last_ready}, 64'd1);
    req_valid = '0; cycle();
    check("rf_x0", {32'd0, rf[0]}, 64'd0);

    // Reset while LOCKED(1) with a transfer in flight
    req_valid = 3'b010; req_lock = 3'b010; addr[1] = 5'd9; data[1] = 32'h1111;
    cycle();
    req_valid = 3'b011; reset = 1'b1; cycle();
    check("midlock_we3", {63'd0, we3}, 64'd0);
    reset = 1'b0; req_valid = 3'b111; req_lock = '0;
    cycle();
    check("after_midlock_grant", {61'd0, last_ready}, 64'd1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      req_valid = N'($urandom_range(0, 7));
      req_lock  = N'($urandom_range(0, 7));
      reset     = ($urandom_range(0, 40) == 0);
      for (int i = 0; i < N; i++) begin
        addr[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        data[i] = $urandom;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
